// File: rtl/lane_pkg.sv
// Shared types and defaults for the inverse vector lane.
package lane_pkg;

  localparam int WIDTH_DEF = 8;
  localparam int SHW_DEF   = 3;

  typedef enum logic [2:0] {
    OP_ADDSUB = 3'd0,
    OP_XOR    = 3'd1,
    OP_SHL    = 3'd2,
    OP_ROT    = 3'd3,
    OP_SHAND  = 3'd4
  } op_e;

  typedef struct packed {
    logic [WIDTH_DEF-1:0] data1;
    logic [WIDTH_DEF-1:0] data2;
    logic [WIDTH_DEF-1:0] key;
    logic [3:0]           select;
  } s1_pay_t;

endpackage

// File: rtl/lane_inverse_alu.sv
// Combinational inverse of the forward lane's per-element operations.
module lane_inverse_alu
  import lane_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int SHW   = SHW_DEF
) (
  input  logic [WIDTH-1:0] data1,
  input  logic [WIDTH-1:0] data2,
  input  logic [WIDTH-1:0] key,
  input  logic [3:0]       select,
  output logic [WIDTH-1:0] result,
  output logic             err
);

  logic [SHW-1:0]     shamt;
  logic [2*WIDTH-1:0] dbl;
  logic [2*WIDTH-1:0] rot_r;
  logic [2*WIDTH-1:0] rot_l;

  // Rotations come from shifting a doubled copy, so s=0 needs no special case.
  assign shamt = data2[SHW-1:0];
  assign dbl   = {data1, data1};
  assign rot_r = dbl >> shamt;
  assign rot_l = dbl << shamt;

  always_comb begin
    result = '0;
    err    = 1'b0;
    case (select[3:1])
      OP_ADDSUB: result = select[0] ? (data1 + data2) : (data1 - data2);
      OP_XOR:    result = data1 ^ data2;
      OP_SHL:    result = select[0] ? (data1 << shamt) : (data1 >> shamt);
      OP_ROT:    result = select[0] ? rot_l[2*WIDTH-1:WIDTH] : rot_r[WIDTH-1:0];
      OP_SHAND:  result = (data1 & key) >> shamt;
      default:   err    = 1'b1;
    endcase
  end

endmodule

// File: rtl/lane_inverse.sv
// Two-stage valid/ready pipeline around the inverse ALU: S1 holds operands,
// S2 holds the result; full backpressure, one element per cycle.
module lane_inverse
  import lane_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int SHW   = SHW_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] data1,
  input  logic [WIDTH-1:0] data2,
  input  logic [WIDTH-1:0] key,
  input  logic [3:0]       select,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] data_out,
  output logic             err,
  output logic             busy
);

  s1_pay_t          s1_pay_q, s1_pay_d;
  logic             s1_valid_q, s1_valid_d;
  logic             s2_valid_q, s2_valid_d;
  logic [WIDTH-1:0] data_out_q, data_out_d;
  logic             err_q, err_d;
  logic [WIDTH-1:0] alu_result;
  logic             alu_err;
  logic             s1_adv, s2_adv;

  // Each stage may advance when empty or when the stage after it advances.
  assign s2_adv = !s2_valid_q || out_ready;
  assign s1_adv = !s1_valid_q || s2_adv;

  lane_inverse_alu #(.WIDTH(WIDTH), .SHW(SHW)) u_alu (
    .data1  (s1_pay_q.data1),
    .data2  (s1_pay_q.data2),
    .key    (s1_pay_q.key),
    .select (s1_pay_q.select),
    .result (alu_result),
    .err    (alu_err)
  );

  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_pay_d   = s1_pay_q;
    s2_valid_d = s2_valid_q;
    data_out_d = data_out_q;
    err_d      = err_q;
    if (s1_adv) begin
      s1_valid_d = in_valid;
      if (in_valid) begin
        s1_pay_d.data1  = data1;
        s1_pay_d.data2  = data2;
        s1_pay_d.key    = key;
        s1_pay_d.select = select;
      end
    end
    if (s2_adv) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        data_out_d = alu_result;
        err_d      = alu_err;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_pay_q   <= '0;
      s2_valid_q <= 1'b0;
      data_out_q <= '0;
      err_q      <= 1'b0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_pay_q   <= s1_pay_d;
      s2_valid_q <= s2_valid_d;
      data_out_q <= data_out_d;
      err_q      <= err_d;
    end
  end

  assign in_ready  = s1_adv;
  assign out_valid = s2_valid_q;
  assign data_out  = data_out_q;
  assign err       = err_q;
  assign busy      = s1_valid_q || s2_valid_q;

endmodule

// File: tb/tb_lane_inverse.sv
// Randomized and directed bench for lane_inverse against a handshake-level
// scoreboard fed by an arithmetic reference of the inverse operations.
module tb_lane_inverse;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] data1 = '0;
  logic [7:0] data2 = '0;
  logic [7:0] key = '0;
  logic [3:0] select = '0;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [7:0] data_out;
  logic       err;
  logic       busy;

  int n_chk = 0;
  int n_bad = 0;

  logic [8:0] sb[$];
  logic       obs_v, obs_e, obs_rdy, obs_busy, last_acc, last_pop;
  logic [7:0] obs_d;

  always #5 clk = ~clk;

  lane_inverse dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .data1     (data1),
    .data2     (data2),
    .key       (key),
    .select    (select),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .data_out  (data_out),
    .err       (err),
    .busy      (busy)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: {err, data} straight from the operation rules, in int arithmetic.
  function automatic logic [8:0] ref_inv(input logic [7:0] d1, input logic [7:0] d2,
                                         input logic [7:0] k, input logic [3:0] sel);
    int a, b, s, r;
    logic e;
    a = d1; b = d2; s = d2 % 8; r = 0; e = 1'b0;
    case (sel >> 1)
      0: r = sel[0] ? (a + b) % 256 : (a - b + 256) % 256;
      1: r = a ^ b;
      2: r = sel[0] ? (a * (1 << s)) % 256 : a / (1 << s);
      3: r = sel[0] ? ((a << s) | (a >> (8 - s))) % 256 : ((a >> s) | (a << (8 - s))) % 256;
      4: r = (a & k) / (1 << s);
      default: begin r = 0; e = 1'b1; end
    endcase
    return {e, r[7:0]};
  endfunction

  // One clock cycle: drive at negedge, observe just after, score handshakes.
  task automatic cycle(input logic v, input logic [7:0] d1, input logic [7:0] d2,
                       input logic [7:0] k, input logic [3:0] sel, input logic ordy);
    logic [8:0] exp;
    @(negedge clk);
    in_valid = v; data1 = d1; data2 = d2; key = k; select = sel; out_ready = ordy;
    #1;
    obs_v = out_valid; obs_d = data_out; obs_e = err; obs_rdy = in_ready; obs_busy = busy;
    last_acc = v && in_ready;
    last_pop = out_valid && ordy;
    if (last_pop) begin
      if (sb.size() == 0) begin
        check("spurious_out", {31'd0, out_valid}, 32'd0);
      end else begin
        exp = sb.pop_front();
        check("sb_data", {24'd0, data_out}, {24'd0, exp[7:0]});
        check("sb_err", {31'd0, err}, {31'd0, exp[8]});
      end
    end
    if (last_acc) sb.push_back(ref_inv(d1, d2, k, sel));
  endtask

  task automatic directed(input string tag, input logic [7:0] d1, input logic [7:0] d2,
                          input logic [7:0] k, input logic [3:0] sel,
                          input logic [7:0] exp_d, input logic exp_e);
    cycle(1'b1, d1, d2, k, sel, 1'b1);
    check({tag, "_accept"}, {31'd0, obs_rdy}, 32'd1);
    cycle(1'b0, 8'h00, 8'h00, 8'h00, 4'h0, 1'b1);
    check({tag, "_early"}, {31'd0, obs_v}, 32'd0);
    cycle(1'b0, 8'h00, 8'h00, 8'h00, 4'h0, 1'b1);
    check({tag, "_valid"}, {31'd0, obs_v}, 32'd1);
    check({tag, "_data"}, {24'd0, obs_d}, {24'd0, exp_d});
    check({tag, "_err"}, {31'd0, obs_e}, {31'd0, exp_e});
    $display("directed %s: data_out=%02h err=%0d", tag, obs_d, obs_e);
  endtask

  initial begin
    logic [7:0] bd1[8], bd2[8], bk[8];
    logic [3:0] bsel[8];
    logic [7:0] held_d, pd1, pd2, pk;
    logic [3:0] psel;
    logic       held_set, ordy, pv;
    int         idx, acc_stall, pops_after, outs, ghost;

    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_out_valid", {31'd0, out_valid}, 32'd0);
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_data", {24'd0, data_out}, 32'd0);
    check("reset_err", {31'd0, err}, 32'd0);
    rst_n = 1'b1;
    #1;
    check("reset_in_ready", {31'd0, in_ready}, 32'd1);

    directed("op0_sub", 8'h05, 8'h07, 8'h00, 4'b0000, 8'hFE, 1'b0);
    directed("op0_add", 8'hFE, 8'h07, 8'h00, 4'b0001, 8'h05, 1'b0);
    directed("op3_rotr", 8'h81, 8'h01, 8'h00, 4'b0110, 8'hC0, 1'b0);
    directed("op3_rotl", 8'h81, 8'h01, 8'h00, 4'b0111, 8'h03, 1'b0);
    directed("op3_s0", 8'h81, 8'h08, 8'h00, 4'b0110, 8'h81, 1'b0);
    directed("op2_shr", 8'h81, 8'h03, 8'h00, 4'b0100, 8'h10, 1'b0);
    directed("op2_shl", 8'h81, 8'h03, 8'h00, 4'b0101, 8'h08, 1'b0);
    directed("op1_xor", 8'hA5, 8'h3C, 8'h00, 4'b0010, 8'h99, 1'b0);
    directed("op4_shand", 8'hF0, 8'h02, 8'h3C, 4'b1001, 8'h0C, 1'b0);
    directed("op6_illegal", 8'hAA, 8'h55, 8'hFF, 4'b1100, 8'h00, 1'b1);
    directed("op1_after_err", 8'h0F, 8'hF0, 8'h00, 4'b0010, 8'hFF, 1'b0);

    // Backpressure: 8 elements offered continuously, sink stalled 5 cycles.
    for (int i = 0; i < 8; i++) begin
      bd1[i] = 8'($urandom); bd2[i] = 8'($urandom); bk[i] = 8'($urandom);
      bsel[i] = 4'($urandom_range(0, 9));
    end
    idx = 0; acc_stall = 0; pops_after = 0; held_set = 1'b0; held_d = '0;
    for (int c = 0; c < 16; c++) begin
      ordy = (c >= 5);
      if (idx < 8) cycle(1'b1, bd1[idx], bd2[idx], bk[idx], bsel[idx], ordy);
      else cycle(1'b0, 8'h00, 8'h00, 8'h00, 4'h0, ordy);
      if (c == 2) check("bp_in_ready_low", {31'd0, obs_rdy}, 32'd0);
      if (c < 5 && last_acc) acc_stall++;
      if (c < 5 && obs_v) begin
        if (!held_set) begin held_d = obs_d; held_set = 1'b1; end
        else check("bp_hold_data", {24'd0, obs_d}, {24'd0, held_d});
      end
      if (c >= 5 && c <= 12 && last_pop) pops_after++;
      if (last_acc) idx++;
    end
    check("bp_acc_during_stall", acc_stall, 2);
    check("bp_consecutive_out", pops_after, 8);
    check("bp_all_accepted", idx, 8);
    check("bp_sb_empty", sb.size(), 0);
    $display("backpressure: stalled_acc=%0d consecutive_out=%0d", acc_stall, pops_after);

    // Streaming: 16 back-to-back inputs with the sink always ready.
    outs = 0;
    for (int c = 0; c < 20; c++) begin
      cycle(c < 16, 8'($urandom), 8'($urandom), 8'($urandom), 4'($urandom_range(0, 15)), 1'b1);
      if (c >= 1 && c <= 17) check("stream_busy", {31'd0, obs_busy}, 32'd1);
      if (c == 18) check("stream_busy_fall", {31'd0, obs_busy}, 32'd0);
      if (c >= 2 && c <= 17 && obs_v) outs++;
    end
    check("stream_consecutive_out", outs, 16);
    check("stream_sb_empty", sb.size(), 0);
    $display("streaming: outputs=%0d", outs);

    // Random traffic; the source holds an offered element until it is accepted.
    pv = 1'b0; pd1 = '0; pd2 = '0; pk = '0; psel = '0;
    for (int c = 0; c < 400; c++) begin
      if (!pv) begin
        pv = ($urandom_range(0, 3) != 0);
        pd1 = 8'($urandom); pd2 = 8'($urandom); pk = 8'($urandom);
        psel = 4'($urandom_range(0, 15));
      end
      cycle(pv, pd1, pd2, pk, psel, $urandom_range(0, 9) < 7);
      if (last_acc) pv = 1'b0;
    end
    for (int c = 0; c < 5; c++) cycle(1'b0, 8'h00, 8'h00, 8'h00, 4'h0, 1'b1);
    check("random_sb_empty", sb.size(), 0);
    $display("random: drained, checks so far=%0d", n_chk);

    // Asynchronous reset with two elements in flight.
    cycle(1'b1, 8'h5A, 8'h33, 8'h00, 4'b0010, 1'b0);
    cycle(1'b1, 8'h11, 8'h00, 8'h00, 4'b1100, 1'b0);
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    check("rst_pre_valid", {31'd0, out_valid}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_err", {31'd0, err}, 32'd0);
    check("rst_data", {24'd0, data_out}, 32'd0);
    sb.delete();
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    ghost = 0;
    for (int c = 0; c < 10; c++) begin
      cycle(1'b0, 8'h00, 8'h00, 8'h00, 4'h0, 1'b1);
      if (obs_v || obs_busy) ghost++;
    end
    check("rst_no_ghost", ghost, 0);
    $display("reset: ghost_cycles=%0d", ghost);

    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_bad);
    $finish;
  end

endmodule
